// File: rtl/ccff_chain_loader.sv
// Serialises valid/ready bitstream words MSB-first onto the configuration-flop chain, one enable per bit.
// Optional CCFF_VERIFY_EN adds CRC-16-CCITT signatures of the bits shifted in (head) and out (tail).
module ccff_chain_loader #(
  parameter int CHAIN_LEN = 256,
  parameter int WORD_W    = 32
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              start,
  input  logic              abort,
  input  logic [WORD_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              ccff_head,
  output logic              chain_clk_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic              error
`ifdef CCFF_VERIFY_EN
  ,
  output logic [15:0]       crc_in,
  output logic [15:0]       crc_out
`endif
);

  localparam int CNT_W  = $clog2(CHAIN_LEN + 1);
  localparam int NWORDS = (CHAIN_LEN + WORD_W - 1) / WORD_W;
  localparam int LAST_R = CHAIN_LEN - WORD_W * (NWORDS - 1);
  localparam int WCNT_W = $clog2(NWORDS + 1);
  localparam int SCNT_W = $clog2(WORD_W + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_DONE} state_t;

  state_t              state, state_d;
  logic [WORD_W-1:0]   sh_data, sh_data_d, hold_data, hold_data_d, in_data;
  logic [SCNT_W-1:0]   sh_cnt, sh_cnt_d, hold_cnt, hold_cnt_d, in_cnt;
  logic                hold_valid, hold_valid_d;
  logic [WCNT_W-1:0]   word_cnt, word_cnt_d;
  logic [CNT_W-1:0]    bit_cnt, bit_cnt_d;
  logic                error_d, en_d, head_d, ready_d;
  logic                shift, accept, last_word;

  assign busy = (state != ST_IDLE);
  assign done = (state == ST_DONE);

  // The final word carries only LAST_R bits in its low end; align them to the MSB.
  assign last_word = (word_cnt == WCNT_W'(NWORDS - 1));
  assign in_data   = last_word ? (s_data << (WORD_W - LAST_R)) : s_data;
  assign in_cnt    = last_word ? SCNT_W'(LAST_R) : SCNT_W'(WORD_W);

  // A registered enable means the shifter held a valid bit in LOAD this cycle.
  assign shift  = chain_clk_en;
  assign accept = s_valid && s_ready;

  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    state_d      = state;
    sh_data_d    = sh_data;
    sh_cnt_d     = sh_cnt;
    hold_data_d  = hold_data;
    hold_cnt_d   = hold_cnt;
    hold_valid_d = hold_valid;
    word_cnt_d   = word_cnt;
    bit_cnt_d    = bit_cnt;
    error_d      = error;
    case (state)
      ST_IDLE: if (start) begin
        state_d      = ST_LOAD;
        error_d      = 1'b0;
        bit_cnt_d    = '0;
        word_cnt_d   = '0;
        sh_cnt_d     = '0;
        hold_valid_d = 1'b0;
      end
      ST_LOAD: begin
        if (shift) begin
          sh_data_d = sh_data << 1;
          sh_cnt_d  = sh_cnt - 1'b1;
          bit_cnt_d = bit_cnt + 1'b1;
        end
        // Reload in the same cycle the last bit leaves, so a full stream has no bubbles.
        if (sh_cnt_d == '0 && hold_valid) begin
          sh_data_d    = hold_data;
          sh_cnt_d     = hold_cnt;
          hold_valid_d = 1'b0;
        end
        if (accept) begin
          word_cnt_d = word_cnt + 1'b1;
          if (sh_cnt_d == '0) begin
            sh_data_d = in_data;
            sh_cnt_d  = in_cnt;
          end else begin
            hold_data_d  = in_data;
            hold_cnt_d   = in_cnt;
            hold_valid_d = 1'b1;
          end
        end
        if (abort) begin
          state_d      = ST_IDLE;
          error_d      = 1'b1;
          sh_cnt_d     = '0;
          hold_valid_d = 1'b0;
        end else if (shift && bit_cnt == CNT_W'(CHAIN_LEN - 1)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    en_d    = (state_d == ST_LOAD) && (sh_cnt_d != '0);
    head_d  = en_d ? sh_data_d[WORD_W-1] : ccff_head;
    ready_d = (state_d == ST_LOAD) && !hold_valid_d && (word_cnt_d < WCNT_W'(NWORDS));
  end

  always_ff @(posedge prog_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (pReset) begin
      state        <= ST_IDLE;
      sh_data      <= '0;
      sh_cnt       <= '0;
      hold_data    <= '0;
      hold_cnt     <= '0;
      hold_valid   <= 1'b0;
      word_cnt     <= '0;
      bit_cnt      <= '0;
      error        <= 1'b0;
      chain_clk_en <= 1'b0;
      ccff_head    <= 1'b0;
      s_ready      <= 1'b0;
    end else begin
      state        <= state_d;
      sh_data      <= sh_data_d;
      sh_cnt       <= sh_cnt_d;
      hold_data    <= hold_data_d;
      hold_cnt     <= hold_cnt_d;
      hold_valid   <= hold_valid_d;
      word_cnt     <= word_cnt_d;
      bit_cnt      <= bit_cnt_d;
      error        <= error_d;
      chain_clk_en <= en_d;
      ccff_head    <= head_d;
      s_ready      <= ready_d;
    end
  end

`ifdef CCFF_VERIFY_EN
  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
    return {c[14:0], 1'b0} ^ ((c[15] ^ b) ? 16'h1021 : 16'h0000);
  endfunction

  // crc_out of a reload equals crc_in of the previous load when the chain is intact.
  always_ff @(posedge prog_clk) begin
    if (pReset || (state == ST_IDLE && start)) begin
      crc_in  <= 16'hFFFF;
      crc_out <= 16'hFFFF;
    end else if (chain_clk_en) begin
      crc_in  <= crc_step(crc_in, ccff_head);
      crc_out <= crc_step(crc_out, ccff_tail);
    end
  end
`else
  logic tail_unused;
  assign tail_unused = ccff_tail;
`endif

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Directed bench for ccff_chain_loader with CHAIN_LEN=40, WORD_W=32 and a 40-bit chain model.
// CRC scenarios are compiled in when CCFF_VERIFY_EN is defined.
module tb_ccff_chain_loader;

  localparam int CHAIN_LEN = 40;
  localparam int WORD_W    = 32;
  localparam logic [39:0] EXP_CHAIN = 40'hA5A5A5A5C3;

  logic        prog_clk = 1'b0;
  logic        pReset, start, abort, s_valid;
  logic [31:0] s_data;
  logic        s_ready, ccff_head, chain_clk_en, ccff_tail, busy, done, error;
`ifdef CCFF_VERIFY_EN
  logic [15:0] crc_in, crc_out;
`endif

  logic [39:0] chain;
  logic        flip_req = 1'b0;

  int pass_cnt = 0, total_cnt = 0, cyc = 0;
  int en_count, stall_count, first_en, last_en, done_cyc, acc_count, acc0_cyc;
  logic stall_head_bad;

  always #5 prog_clk = ~prog_clk;

  ccff_chain_loader #(.CHAIN_LEN(CHAIN_LEN), .WORD_W(WORD_W)) dut (
    .prog_clk    (prog_clk),
    .pReset      (pReset),
    .start       (start),
    .abort       (abort),
    .s_data      (s_data),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .ccff_head   (ccff_head),
    .chain_clk_en(chain_clk_en),
    .ccff_tail   (ccff_tail),
    .busy        (busy),
    .done        (done),
    .error       (error)
`ifdef CCFF_VERIFY_EN
    ,
    .crc_in      (crc_in),
    .crc_out     (crc_out)
`endif
  );

  // Fabric chain: head enters bit 0, tail is bit 39.
  assign ccff_tail = chain[39];
  always @(posedge prog_clk) begin
    if (chain_clk_en) chain <= {chain[38:0], ccff_head};
    else if (flip_req) chain[20] <= ~chain[20];
  end

  task automatic tick();
    @(posedge prog_clk);
    #1;
    cyc++;
  endtask

  // Word 0 is A5A5A5A5, word 1 is w1, then a junk word that must never be taken.
  task automatic run_load(input logic [31:0] w1, input int delay, input int stop_en, input int start_at);
    int wi, low_left;
    logic acc;
    en_count = 0; stall_count = 0; first_en = -1; last_en = -1;
    done_cyc = -1; acc_count = 0; acc0_cyc = -1; stall_head_bad = 1'b0;
    abort = 1'b0; s_valid = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    wi = 0; low_left = 0;
    for (int c = 0; c < 200; c++) begin
      start   = (start_at > 0) && (en_count == start_at);
      s_valid = (wi < 3) && (low_left == 0);
      s_data  = (wi == 0) ? 32'hA5A5A5A5 : (wi == 1) ? w1 : 32'hFFFFFFFF;
      if (chain_clk_en) begin
        en_count++;
        if (first_en < 0) first_en = cyc;
        last_en = cyc;
      end else if (first_en >= 0 && en_count < CHAIN_LEN) begin
        stall_count++;
        if (ccff_head !== 1'b1) stall_head_bad = 1'b1;
      end
      if (done) done_cyc = cyc;
      if (done || (stop_en > 0 && chain_clk_en && en_count == stop_en)) break;
      acc = s_valid && s_ready;
      if (acc) begin
        if (wi == 0) begin acc0_cyc = cyc; low_left = delay; end
        wi++;
        acc_count++;
      end else if (wi == 1 && low_left > 0) begin
        low_left--;
      end
      tick();
    end
    s_valid = 1'b0;
    start   = 1'b0;
  endtask

  task automatic test_reset();
    pReset = 1'b1; start = 1'b0; abort = 1'b0; s_valid = 1'b0; s_data = '0;
    tick(); tick();
    pReset = 1'b0;
    total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else pass_cnt++;
    total_cnt++; if (s_ready !== 1'b0) $display("FAIL reset_s_ready: got %b want 0", s_ready); else pass_cnt++;
    total_cnt++; if (chain_clk_en !== 1'b0) $display("FAIL reset_en: got %b want 0", chain_clk_en); else pass_cnt++;
    total_cnt++; if (ccff_head !== 1'b0) $display("FAIL reset_head: got %b want 0", ccff_head); else pass_cnt++;
    total_cnt++; if ({done, error} !== 2'b00) $display("FAIL reset_done_error: got %b want 00", {done, error}); else pass_cnt++;
`ifdef CCFF_VERIFY_EN
    total_cnt++; if (crc_in !== 16'hFFFF || crc_out !== 16'hFFFF) $display("FAIL reset_crc: got %h/%h want FFFF/FFFF", crc_in, crc_out); else pass_cnt++;
`endif
  endtask

  task automatic test_stream();
    run_load(32'h000000C3, 0, 0, 0);
    total_cnt++; if (en_count !== 40) $display("FAIL stream_enables: got %0d want 40", en_count); else pass_cnt++;
    total_cnt++; if (stall_count !== 0) $display("FAIL stream_bubbles: got %0d want 0", stall_count); else pass_cnt++;
    total_cnt++; if (first_en !== acc0_cyc + 1) $display("FAIL stream_first_latency: got %0d want %0d", first_en, acc0_cyc + 1); else pass_cnt++;
    total_cnt++; if (done_cyc !== last_en + 1) $display("FAIL stream_done_latency: got %0d want %0d", done_cyc, last_en + 1); else pass_cnt++;
    total_cnt++; if (acc_count !== 2) $display("FAIL stream_words_taken: got %0d want 2", acc_count); else pass_cnt++;
    total_cnt++; if (chain !== EXP_CHAIN) $display("FAIL stream_chain: got %h want %h", chain, EXP_CHAIN); else pass_cnt++;
    tick();
    total_cnt++; if ({busy, done} !== 2'b00) $display("FAIL stream_back_idle: got %b want 00", {busy, done}); else pass_cnt++;
  endtask

  // Word 1 withheld 36 cycles after word 0: the shifter drains and idles for 5 cycles.
  task automatic test_stall();
    run_load(32'hDEADBEC3, 36, 0, 0);
    total_cnt++; if (en_count !== 40) $display("FAIL stall_enables: got %0d want 40", en_count); else pass_cnt++;
    total_cnt++; if (stall_count !== 5) $display("FAIL stall_cycles: got %0d want 5", stall_count); else pass_cnt++;
    total_cnt++; if (stall_head_bad !== 1'b0) $display("FAIL stall_head_hold: got %b want 0", stall_head_bad); else pass_cnt++;
    total_cnt++; if (chain !== EXP_CHAIN) $display("FAIL stall_chain: got %h want %h", chain, EXP_CHAIN); else pass_cnt++;
    total_cnt++; if (done_cyc !== last_en + 1) $display("FAIL stall_done_latency: got %0d want %0d", done_cyc, last_en + 1); else pass_cnt++;
    tick();
  endtask

  task automatic test_abort();
    run_load(32'h000000C3, 0, 10, 0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    total_cnt++; if (en_count !== 10) $display("FAIL abort_enables: got %0d want 10", en_count); else pass_cnt++;
    total_cnt++; if ({busy, error, s_ready, chain_clk_en, done} !== 5'b01000) $display("FAIL abort_state: got %b want 01000", {busy, error, s_ready, chain_clk_en, done}); else pass_cnt++;
    total_cnt++; if (chain[9:0] !== 10'h296) $display("FAIL abort_partial_chain: got %h want 296", chain[9:0]); else pass_cnt++;
    tick();
    total_cnt++; if (error !== 1'b1) $display("FAIL abort_sticky: got %b want 1", error); else pass_cnt++;
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    total_cnt++; if ({busy, error} !== 2'b10) $display("FAIL start_abort_idle: got %b want 10", {busy, error}); else pass_cnt++;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    total_cnt++; if ({busy, error} !== 2'b01) $display("FAIL abort_empty_load: got %b want 01", {busy, error}); else pass_cnt++;
  endtask

  task automatic test_abort_final();
    run_load(32'h000000C3, 0, 40, 0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    total_cnt++; if ({busy, done, error} !== 3'b001) $display("FAIL abort_final_state: got %b want 001", {busy, done, error}); else pass_cnt++;
    total_cnt++; if (chain !== EXP_CHAIN) $display("FAIL abort_final_chain: got %h want %h", chain, EXP_CHAIN); else pass_cnt++;
    tick();
    total_cnt++; if (done !== 1'b0) $display("FAIL abort_final_no_done: got %b want 0", done); else pass_cnt++;
  endtask

  task automatic test_reset_mid_load();
    run_load(32'h000000C3, 0, 17, 0);
    total_cnt++; if (ccff_head !== 1'b1) $display("FAIL midload_head_bit16: got %b want 1", ccff_head); else pass_cnt++;
    pReset = 1'b1;
    tick();
    pReset = 1'b0;
    total_cnt++; if ({busy, s_ready, chain_clk_en, ccff_head, done, error} !== 6'b000000) $display("FAIL midload_reset: got %b want 000000", {busy, s_ready, chain_clk_en, ccff_head, done, error}); else pass_cnt++;
`ifdef CCFF_VERIFY_EN
    total_cnt++; if (crc_in !== 16'hFFFF) $display("FAIL midload_crc_reset: got %h want FFFF", crc_in); else pass_cnt++;
`endif
    run_load(32'h000000C3, 0, 0, 0);
    total_cnt++; if (en_count !== 40 || chain !== EXP_CHAIN) $display("FAIL midload_reload: got %0d/%h want 40/%h", en_count, chain, EXP_CHAIN); else pass_cnt++;
    tick();
  endtask

  task automatic test_idle_and_start_ignore();
    s_valid = 1'b1; s_data = 32'h12345678;
    for (int i = 0; i < 3; i++) begin
      tick();
      total_cnt++; if ({busy, s_ready} !== 2'b00) $display("FAIL idle_ready: got %b want 00", {busy, s_ready}); else pass_cnt++;
    end
    s_valid = 1'b0;
    run_load(32'h000000C3, 0, 0, 5);
    total_cnt++; if (en_count !== 40) $display("FAIL start_in_load_enables: got %0d want 40", en_count); else pass_cnt++;
    total_cnt++; if (chain !== EXP_CHAIN) $display("FAIL start_in_load_chain: got %h want %h", chain, EXP_CHAIN); else pass_cnt++;
    total_cnt++; if (done_cyc !== last_en + 1) $display("FAIL start_in_load_done: got %0d want %0d", done_cyc, last_en + 1); else pass_cnt++;
    tick();
  endtask

`ifdef CCFF_VERIFY_EN
  function automatic logic [15:0] crc_model(input logic [39:0] bits);
    logic [15:0] c;
    c = 16'hFFFF;
    for (int i = 39; i >= 0; i--) c = {c[14:0], 1'b0} ^ ((c[15] ^ bits[i]) ? 16'h1021 : 16'h0000);
    return c;
  endfunction

  task automatic test_crc();
    logic [15:0] crc1, exp_crc;
    exp_crc = crc_model(EXP_CHAIN);
    run_load(32'h000000C3, 0, 0, 0);
    crc1 = crc_in;
    total_cnt++; if (crc1 !== exp_crc) $display("FAIL crc_in_value: got %h want %h", crc1, exp_crc); else pass_cnt++;
    tick();
    run_load(32'h000000C3, 0, 0, 0);
    total_cnt++; if (crc_out !== exp_crc) $display("FAIL crc_out_intact: got %h want %h", crc_out, exp_crc); else pass_cnt++;
    total_cnt++; if (crc_in !== exp_crc) $display("FAIL crc_in_repeat: got %h want %h", crc_in, exp_crc); else pass_cnt++;
    tick();
    flip_req = 1'b1;
    tick();
    flip_req = 1'b0;
    run_load(32'h000000C3, 0, 0, 0);
    total_cnt++; if (crc_out === exp_crc) $display("FAIL crc_out_corrupt: got %h want not %h", crc_out, exp_crc); else pass_cnt++;
    tick();
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_abort();
    test_abort_final();
    test_reset_mid_load();
    test_idle_and_start_ignore();
`ifdef CCFF_VERIFY_EN
    test_crc();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
